// File: rtl/parity_step_counter.sv
// Even/odd stride counter: counts by 2 through values of one parity, with load, enable and wrap/saturate limits.
// Latency: one clk from sampled inputs to data_out/tc/sat; aligned is combinational on data_out and parity_sel.
// Backpressure: none; the count advances on every enabled edge, and load takes priority over en.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears data_out, tc, sat)
//   load       synchronous parallel load of data_in (priority over en)
//   data_in    load value, either parity
//   en         count enable
//   up         1: count up, 0: count down
//   parity_sel 0: even sequence, 1: odd sequence
//   data_out   registered count
//   aligned    data_out[0] == parity_sel
//   tc         one-cycle pulse on a wrap or saturation event
//   sat        sticky saturation flag, cleared by load or rst
module parity_step_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             up,
  input  logic             parity_sel,
  output logic [WIDTH-1:0] data_out,
  output logic             aligned,
  output logic             tc,
  output logic             sat
);

  localparam logic [WIDTH:0]   ONE     = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   TWO     = (WIDTH+1)'(2);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;
  localparam logic [WIDTH-1:0] MAX_M1  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] VAL_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;

  // Extra top bit carries the carry/borrow used for limit detection.
  logic [WIDTH:0]   inc1, dec1, inc2, dec2;
  logic [WIDTH-1:0] lo_p, hi_p;

  always_comb begin
    inc1 = {1'b0, cnt_q} + ONE;
    dec1 = {1'b0, cnt_q} - ONE;
    inc2 = {1'b0, cnt_q} + TWO;
    dec2 = {1'b0, cnt_q} - TWO;
    // Lowest / highest value of the selected parity: LSB is the parity, the rest are 0s / 1s.
    lo_p = {{(WIDTH-1){1'b0}}, parity_sel};
    hi_p = {{(WIDTH-1){1'b1}}, parity_sel};
  end

  assign aligned = (cnt_q[0] == parity_sel);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    sat_d = sat_q;
    if (load) begin
      cnt_d = data_in;
      sat_d = 1'b0;
    end else if (en) begin
      if (!aligned) begin
        // Single step onto the selected parity.
        if (up) begin
          if (inc1[WIDTH]) begin
            tc_d = 1'b1;
            if (WRAP) begin
              cnt_d = '0;
            end else begin
              cnt_d = MAX_M1;
              sat_d = 1'b1;
            end
          end else begin
            cnt_d = inc1[WIDTH-1:0];
          end
        end else begin
          if (dec1[WIDTH]) begin
            tc_d = 1'b1;
            if (WRAP) begin
              cnt_d = ALL_ONE;
            end else begin
              cnt_d = VAL_ONE;
              sat_d = 1'b1;
            end
          end else begin
            cnt_d = dec1[WIDTH-1:0];
          end
        end
      end else begin
        // Stride of 2 within the parity; a carry/borrow means we sit on HI_p/LO_p.
        if (up) begin
          if (inc2[WIDTH]) begin
            tc_d = 1'b1;
            if (WRAP) begin
              cnt_d = lo_p;
            end else begin
              sat_d = 1'b1;
            end
          end else begin
            cnt_d = inc2[WIDTH-1:0];
          end
        end else begin
          if (dec2[WIDTH]) begin
            tc_d = 1'b1;
            if (WRAP) begin
              cnt_d = hi_p;
            end else begin
              sat_d = 1'b1;
            end
          end else begin
            cnt_d = dec2[WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      sat_q <= sat_d;
    end
  end

  assign data_out = cnt_q;
  assign tc       = tc_q;
  assign sat      = sat_q;

endmodule
